// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch PC stage.
package pc_pkg;

  localparam int unsigned PC_W_DEF = 32;

  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [PC_W_DEF-1:0] EXC_VEC_DEF  = 32'h0000_4180;

  localparam int unsigned CLA_SLICE_W = 4;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_RST  = 3'd0,
    SEL_EXC  = 3'd1,
    SEL_HOLD = 3'd2,
    SEL_JR   = 3'd3,
    SEL_BR   = 3'd4,
    SEL_SEQ  = 3'd5
  } pc_sel_e;

endpackage : pc_pkg

// File: rtl/pc_unit_cla_adder_n.sv
// N-bit adder built as a ripple of 4-bit carry-lookahead slices.
module cla_adder_n
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int unsigned NSLICE = WIDTH / CLA_SLICE_W;

  // Carry into each slice; c[NSLICE] is the final carry-out.
  logic [NSLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < int'(NSLICE); i++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    // Bit generate/propagate for this slice.
    assign g = x[4*i +: 4] & y[4*i +: 4];
    assign p = x[4*i +: 4] ^ y[4*i +: 4];

    // Lookahead carries inside the slice, all derived from the slice carry-in.
    assign cc[0] = c[i];
    assign cc[1] = g[0] | (p[0] & cc[0]);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc[0]);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cc[0]);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cc[0]);

    assign s[4*i +: 4] = p ^ cc[3:0];
    assign c[i+1]      = cc[4];
  end

  assign cout = c[NSLICE];

endmodule : cla_adder_n

// File: rtl/pc_unit.sv
// Fetch program counter: registered PC with priority next-PC selection and
// misaligned-jump redirection to the exception vector.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned           WIDTH    = 32,
  parameter logic [WIDTH-1:0]      RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter logic [WIDTH-1:0]      EXC_VEC  = WIDTH'(EXC_VEC_DEF),
  parameter int unsigned           INC      = 4,
  parameter int unsigned           OFF_W    = 16,
  parameter int unsigned           ALIGN    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jr_en,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             misalign,
  output logic [WIDTH-1:0] bad_addr
);

  localparam int unsigned EXT_W = WIDTH - OFF_W;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] bad_addr_q, bad_addr_d;

  pc_sel_e          sel_c;
  logic             jr_misaligned_c;
  logic [WIDTH-1:0] br_off_sh_c;
  logic [WIDTH-1:0] br_target_c;
  logic             inc_cout_unused;
  logic             br_cout_unused;

  // Sequential successor of the current PC.
  cla_adder_n #(.WIDTH(WIDTH)) u_inc_add (
    .x    (pc_q),
    .y    (WIDTH'(INC)),
    .cin  (1'b0),
    .s    (pc_plus_inc),
    .cout (inc_cout_unused)
  );

  // Branch offset is in instruction words: sign-extend then scale to bytes.
  always_comb begin
    br_off_sh_c = {{EXT_W{br_off[OFF_W-1]}}, br_off} << ALIGN;
  end

  // Branch target is relative to the sequential successor.
  cla_adder_n #(.WIDTH(WIDTH)) u_br_add (
    .x    (pc_plus_inc),
    .y    (br_off_sh_c),
    .cin  (1'b0),
    .s    (br_target_c),
    .cout (br_cout_unused)
  );

  // Jump targets must have their low ALIGN bits clear.
  always_comb begin
    jr_misaligned_c = |jr_addr[ALIGN-1:0];
  end

  // Priority select of the next-PC source.
  always_comb begin
    sel_c = SEL_SEQ;
    if (rst)           sel_c = SEL_RST;
    else if (exc)      sel_c = SEL_EXC;
    else if (stall)    sel_c = SEL_HOLD;
    else if (jr_en)    sel_c = SEL_JR;
    else if (br_taken) sel_c = SEL_BR;
  end

  // Next-state values for PC and the misalignment report.
  always_comb begin
    pc_d       = pc_plus_inc;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
    unique case (sel_c)
      SEL_RST: begin
        pc_d       = RESET_PC;
        bad_addr_d = '0;
      end
      SEL_EXC:  pc_d = EXC_VEC;
      SEL_HOLD: pc_d = pc_q;
      SEL_JR: begin
        if (jr_misaligned_c) begin
          pc_d       = EXC_VEC;
          misalign_d = 1'b1;
          bad_addr_d = jr_addr;
        end else begin
          pc_d = jr_addr;
        end
      end
      SEL_BR:  pc_d = br_target_c;
      SEL_SEQ: pc_d = pc_plus_inc;
      default: pc_d = pc_plus_inc;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed and randomized check of pc_unit against a behavioural PC model.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        misalign;
  logic [31:0] bad_addr;

  int n_pass;
  int n_total;

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_bad;

  pc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_off      (br_off),
    .jr_en       (jr_en),
    .jr_addr     (jr_addr),
    .exc         (exc),
    .pc          (pc),
    .pc_plus_inc (pc_plus_inc),
    .misalign    (misalign),
    .bad_addr    (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply one cycle of controls, advance the model, and compare all outputs.
  task automatic step(input logic r, input logic e, input logic s, input logic j,
                      input logic [31:0] ja, input logic b, input logic [15:0] off);
    int soff;
    rst = r; exc = e; stall = s; jr_en = j; jr_addr = ja; br_taken = b; br_off = off;
    @(posedge clk);
    #1;
    soff = int'($signed(off));
    if (r) begin
      m_pc = 32'h0000_3000; m_mis = 1'b0; m_bad = 32'h0;
    end else if (e) begin
      m_pc = 32'h0000_4180; m_mis = 1'b0;
    end else if (s) begin
      m_mis = 1'b0;
    end else if (j) begin
      if (ja % 4 != 0) begin
        m_pc = 32'h0000_4180; m_mis = 1'b1; m_bad = ja;
      end else begin
        m_pc = ja; m_mis = 1'b0;
      end
    end else if (b) begin
      m_pc = m_pc + 32'd4 + 32'(soff * 4); m_mis = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4; m_mis = 1'b0;
    end
    chk("pc", pc, m_pc);
    chk("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("bad_addr", bad_addr, m_bad);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    m_pc = 32'h0; m_mis = 1'b0; m_bad = 32'h0;
    rst = 1'b1; exc = 1'b0; stall = 1'b0; jr_en = 1'b0; jr_addr = 32'h0;
    br_taken = 1'b0; br_off = 16'h0;

    // Reset sequence then sequential fetch.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    chk("t1_reset_pc", pc, 32'h0000_3000);
    chk("t1_reset_mis", {31'b0, misalign}, 32'h0);
    idle(); chk("t1_seq1", pc, 32'h0000_3004);
    idle(); chk("t1_seq2", pc, 32'h0000_3008);
    idle(); chk("t1_seq3", pc, 32'h0000_300C);

    // Backward branch from 0x3008.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0);
    idle(); idle();
    chk("t2_at", pc, 32'h0000_3008);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 16'hFFFE);
    chk("t2_back_br", pc, 32'h0000_3004);

    // Stall drops a simultaneous branch.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 16'h0010);
    chk("t3_stall", pc, 32'h0000_3004);
    idle(); chk("t3_resume", pc, 32'h0000_3008);

    // Misaligned then aligned jump.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4001, 1'b0, 16'h0);
    chk("t4_mis_pc", pc, 32'h0000_4180);
    chk("t4_mis_flag", {31'b0, misalign}, 32'h1);
    chk("t4_bad", bad_addr, 32'h0000_4001);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 16'h0);
    chk("t4_jr_pc", pc, 32'h0000_5000);
    chk("t4_jr_flag", {31'b0, misalign}, 32'h0);
    chk("t4_bad_hold", bad_addr, 32'h0000_4001);

    // exc beats stall and a misaligned jump; then wrap at the top of memory.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_4003, 1'b0, 16'h0);
    chk("t5_exc_pc", pc, 32'h0000_4180);
    chk("t5_exc_flag", {31'b0, misalign}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 16'h0);
    idle();
    chk("t5_wrap", pc, 32'h0000_0000);
    chk("t5_wrap_flag", {31'b0, misalign}, 32'h0);

    // Reset overrides a branch mid-operation.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 16'h0040);
    chk("t6_rst_pc", pc, 32'h0000_3000);
    chk("t6_rst_bad", bad_addr, 32'h0);
    chk("t6_rst_flag", {31'b0, misalign}, 32'h0);

    // Randomized mix of all controls.
    for (int i = 0; i < 400; i++) begin
      logic        r, e, s, j, b;
      logic [31:0] ja;
      logic [15:0] off;
      r   = ($urandom_range(0, 31) == 0);
      e   = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 4) == 0);
      b   = ($urandom_range(0, 2) == 0);
      ja  = $urandom;
      if ($urandom_range(0, 1) == 0) ja[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) ja = 32'hFFFF_FFFC;
      off = 16'($urandom);
      step(r, e, s, j, ja, b, off);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parameterised program-counter stage for the CPU fetch front end.
- Holds the registered PC and selects the next PC each cycle from five sources: sequential increment, PC-relative branch, register jump, exception vector, or stall hold.
- Detects misaligned jump targets and redirects them to the exception vector.
- All address arithmetic uses a parameterised carry-lookahead adder built from 4-bit CLA slices.

Parameters:
WIDTH, 32, PC/address width in bits; must be a multiple of 4.
RESET_PC, 32'h0000_3000, PC value loaded on reset.
EXC_VEC, 32'h0000_4180, exception/trap entry address.
INC, 4, sequential increment in bytes.
OFF_W, 16, branch offset field width.
ALIGN, 2, number of low PC bits that must be zero; also the branch-offset left shift.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC this cycle
br_taken  in  1  take PC-relative branch
br_off  in  OFF_W  signed branch offset, in instruction words
jr_en  in  1  take register jump
jr_addr  in  WIDTH  absolute jump target
exc  in  1  exception request
pc  out  WIDTH  current registered PC
pc_plus_inc  out  WIDTH  combinational pc + INC
misalign  out  1  registered one-cycle pulse: a jump was redirected due to misalignment
bad_addr  out  WIDTH  registered offending jump target; holds until the next misalign

Behaviour:
- Reset: on a clock edge with rst=1, pc=RESET_PC, misalign=0, bad_addr=0. rst overrides every other input, including mid-sequence.
- Next-PC priority, highest first: rst > exc > stall > jr_en > br_taken > sequential.
- exc: pc<=EXC_VEC, misalign<=0. exc overrides stall.
- stall (no exc): pc holds; misalign<=0. Any br_taken or jr_en in the same cycle is dropped; the pipeline re-presents it.
- jr_en: if jr_addr[ALIGN-1:0]==0, pc<=jr_addr. Otherwise pc<=EXC_VEC, misalign<=1, bad_addr<=jr_addr.
- br_taken: pc <= pc_plus_inc + (sign_extend(br_off) << ALIGN).
  - Computed modulo 2^WIDTH.
  - Always aligned when pc is aligned, so never flagged.
- Default: pc <= pc_plus_inc, modulo 2^WIDTH. 0xFFFF_FFFC wraps to 0x0000_0000 with no error and no flag.
- misalign is high for exactly the cycle after a misaligned jr_en was accepted, and 0 otherwise.
- Adders are purely combinational; carry-out is discarded.
- Latency: a control input sampled at edge N is visible on pc immediately after edge N. No bubbles.
- pc_plus_inc follows pc combinationally with zero cycle latency.

Decomposition:
- Package pc_pkg: RESET_PC and EXC_VEC default constants, plus a next-PC-select enum {SEL_RST, SEL_EXC, SEL_HOLD, SEL_JR, SEL_BR, SEL_SEQ}.
- Sub-module cla_adder_n (parameter WIDTH):
  - Ripple of 4-bit carry-lookahead slices.
  - Ports: x, y, cin, s, cout.
  - pc_unit instantiates it twice: pc+INC, and pc_plus_inc+shifted offset.

Test Plan:
1. Reset sequence: hold rst for 2 cycles, release, no controls for 3 cycles -> pc reads 0x3000, 0x3004, 0x3008, 0x300C; misalign stays 0.
2. Backward branch: at pc=0x3008 assert br_taken with br_off=16'hFFFE -> next pc = 0x300C - 8 = 0x3004.
3. Stall beats branch: stall=1 with br_taken=1, br_off=0x0010 at pc=0x3004 -> pc stays 0x3004. Next cycle with no controls -> pc=0x3008.
4. Misaligned jump: jr_en with jr_addr=0x0000_4001 -> pc=0x4180, misalign=1 for one cycle, bad_addr=0x4001. Then jr_en with jr_addr=0x0000_5000 -> pc=0x5000, misalign=0, bad_addr still 0x4001.
5. Priority and wrap: exc, stall and a misaligned jr_en together -> pc=0x4180, misalign=0. Separately, from pc=0xFFFF_FFFC with no controls -> pc=0x0000_0000.
6. Reset mid-operation: assert rst in the same cycle as br_taken at pc=0x5000 -> pc=0x3000, bad_addr=0, misalign=0.
